// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU function codes, FSM states and IR field layout for the control sequencer
package ctrl_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [4:0] FS_PASSA = 5'h00;
    localparam logic [4:0] FS_ADD   = 5'h01;
    localparam logic [4:0] FS_SUB   = 5'h02;
    localparam logic [4:0] FS_AND   = 5'h03;
    localparam logic [4:0] FS_OR    = 5'h04;
    localparam logic [4:0] FS_XOR   = 5'h05;
    localparam logic [4:0] FS_NOT   = 5'h06;
    localparam logic [4:0] FS_SHL   = 5'h07;
    localparam logic [4:0] FS_SHR   = 5'h08;
    localparam logic [4:0] FS_PASSB = 5'h09;
    // OR-ed into FS when the ALU B operand must come from k instead of the register file
    localparam logic [4:0] FS_KSEL  = 5'h10;

    localparam int IR_OP_LSB = 12;
    localparam int IR_DA_LSB = 9;
    localparam int IR_AA_LSB = 6;
    localparam int IR_BA_LSB = 3;
    localparam int IMM6_W    = 6;
    localparam int IMM9_W    = 9;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4,
        WAIT   = 3'd5
    } state_t;
endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control word, memory handshake and status bundle (STEP_EN adds step)
interface control_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 8
);
    logic [WIDTH-1:0] instr;
    logic             mem_ready;
    logic             zero;
    logic             Cout;
`ifdef STEP_EN
    logic             step;
`endif
    logic [PC_W-1:0]  pc;
    logic [2:0]       AA;
    logic [2:0]       BA;
    logic [2:0]       DA;
    logic [4:0]       FS;
    logic [WIDTH-1:0] k;
    logic             Cin;
    logic             WR;
    logic             MW;
    logic             MA;
    logic             MD;
    logic             IR_L;
    logic             PS;
    logic             halted;
    logic             zflag;
    logic             cflag;

    modport master (
        input  instr, mem_ready, zero, Cout,
        output pc, AA, BA, DA, FS, k, Cin, WR, MW, MA, MD, IR_L, PS, halted, zflag, cflag
`ifdef STEP_EN
        , input step
`endif
    );

    modport slave (
        output instr, mem_ready, zero, Cout,
        input  pc, AA, BA, DA, FS, k, Cin, WR, MW, MA, MD, IR_L, PS, halted, zflag, cflag
`ifdef STEP_EN
        , output step
`endif
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode classification and ALU function select
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [4:0] o_fs,
    output logic       o_cin,
    output logic       o_use_k,
    output logic       o_is_alu,
    output logic       o_is_mem,
    output logic       o_is_branch
);
    always_comb begin
        o_fs        = FS_PASSA;
        o_cin       = 1'b0;
        o_use_k     = 1'b0;
        o_is_alu    = 1'b0;
        o_is_mem    = 1'b0;
        o_is_branch = 1'b0;
        case (i_op)
            OP_ADD:  begin o_fs = FS_ADD; o_is_alu = 1'b1; end
            OP_SUB:  begin o_fs = FS_SUB; o_cin = 1'b1; o_is_alu = 1'b1; end
            OP_AND:  begin o_fs = FS_AND; o_is_alu = 1'b1; end
            OP_OR:   begin o_fs = FS_OR;  o_is_alu = 1'b1; end
            OP_XOR:  begin o_fs = FS_XOR; o_is_alu = 1'b1; end
            OP_NOT:  begin o_fs = FS_NOT; o_is_alu = 1'b1; end
            OP_SHL:  begin o_fs = FS_SHL; o_is_alu = 1'b1; end
            OP_SHR:  begin o_fs = FS_SHR; o_is_alu = 1'b1; end
            OP_ADDI: begin o_fs = FS_ADD;   o_use_k = 1'b1; o_is_alu = 1'b1; end
            OP_LDI:  begin o_fs = FS_PASSB; o_use_k = 1'b1; o_is_alu = 1'b1; end
            OP_LD, OP_ST:  o_is_mem = 1'b1;
            OP_BZ, OP_JMP: o_is_branch = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM sequencer holding PC, IR and Z/C flags
// STEP_EN: single-step mode, every return to FETCH parks in WAIT until step=1.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int              WIDTH    = 16,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock_50,
    input  logic               clear,
    control_sequencer_if.master bus
);
`ifdef STEP_EN
    localparam state_t DONE_ST = WAIT;
`else
    localparam state_t DONE_ST = FETCH;
`endif

    state_t           r_state, w_next;
    logic [PC_W-1:0]  r_pc, w_pc_next;
    logic [WIDTH-1:0] r_ir;
    logic             r_zflag, r_cflag;
    logic             w_ir_load, w_flag_load;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_k;
    logic [4:0]       w_fs;
    logic             w_cin, w_use_k, w_is_alu, w_is_mem, w_is_branch;

    assign w_op = r_ir[IR_OP_LSB +: 4];
    assign w_k  = (w_op == OP_JMP) ? {{(WIDTH-IMM9_W){r_ir[IMM9_W-1]}}, r_ir[IMM9_W-1:0]}
                                   : {{(WIDTH-IMM6_W){r_ir[IMM6_W-1]}}, r_ir[IMM6_W-1:0]};

    ctrl_decode u_decode (
        .i_op        (w_op),
        .o_fs        (w_fs),
        .o_cin       (w_cin),
        .o_use_k     (w_use_k),
        .o_is_alu    (w_is_alu),
        .o_is_mem    (w_is_mem),
        .o_is_branch (w_is_branch)
    );

    assign bus.pc    = r_pc;
    assign bus.DA    = r_ir[IR_DA_LSB +: 3];
    assign bus.AA    = r_ir[IR_AA_LSB +: 3];
    assign bus.BA    = r_ir[IR_BA_LSB +: 3];
    assign bus.k     = w_k;
    assign bus.FS    = w_fs | (w_use_k ? FS_KSEL : 5'h00);
    assign bus.Cin   = w_cin;
    assign bus.zflag = r_zflag;
    assign bus.cflag = r_cflag;

    always_ff @(posedge clock_50 or posedge clear) begin
        if (clear) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_zflag <= 1'b0;
            r_cflag <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_ir_load) r_ir <= bus.instr;
            if (w_flag_load) begin
                r_zflag <= bus.zero;
                r_cflag <= bus.Cout;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_ir_load   = 1'b0;
        w_flag_load = 1'b0;
        bus.WR      = 1'b0;
        bus.MW      = 1'b0;
        bus.IR_L    = 1'b0;
        bus.PS      = 1'b0;
        bus.halted  = 1'b0;
        bus.MA      = 1'b1;
        bus.MD      = 1'b0;
        case (r_state)
            FETCH: begin
                bus.IR_L = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_ir_load = 1'b1;
                    w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    w_next    = DECODE;
                end
            end
            DECODE: begin
                if (w_op == OP_NOP)       w_next = DONE_ST;
                else if (w_op == OP_HALT) w_next = HALT;
                else                      w_next = EXEC;
            end
            EXEC: begin
                if (w_is_alu) begin
                    bus.WR      = 1'b1;
                    w_flag_load = 1'b1;
                    w_next      = DONE_ST;
                end else if (w_is_mem) begin
                    w_next = MEM;
                end else if (w_is_branch) begin
                    // pc already points past the branch, so the offset is relative to pc+1
                    if (w_op == OP_JMP || r_zflag) begin
                        bus.PS    = 1'b1;
                        w_pc_next = r_pc + w_k[PC_W-1:0];
                    end
                    w_next = DONE_ST;
                end else begin
                    w_next = DONE_ST;
                end
            end
            MEM: begin
                bus.MA = 1'b0;
                if (w_op == OP_LD) begin
                    bus.MD = 1'b1;
                    bus.WR = bus.mem_ready;
                end else begin
                    bus.MW = 1'b1;
                end
                if (bus.mem_ready) w_next = DONE_ST;
            end
            HALT: bus.halted = 1'b1;
            WAIT: begin
`ifdef STEP_EN
                if (bus.step) w_next = FETCH;
`else
                w_next = FETCH;
`endif
            end
            default: w_next = FETCH;
        endcase
        // clear kills enables combinationally so nothing partial escapes in the asserting cycle
        if (clear) begin
            bus.WR     = 1'b0;
            bus.MW     = 1'b0;
            bus.IR_L   = 1'b0;
            bus.PS     = 1'b0;
            bus.halted = 1'b0;
            bus.MA     = 1'b1;
        end
    end
endmodule
